ex2_mem_resp: RTL and testbench

Load/store response stage on the EX2 side of the data-cache interface. It sits downstream of the EX0→EX1 memory-issue buffer, which drives the dcache request (op, write type, address, write data, atomic flag). This block accepts a description of each issued memory op, waits for the dcache response, and aligns and sign/zero-extends load data. It holds the result for the writeback stage, exposes it for forwarding, and discards in-flight responses after a flush.

---
 rtl/ex2_mem_resp.sv | 118 +++++++++++
 tb/tb_ex2_mem_resp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex2_mem_resp.sv
// rtl/ex2_mem_resp.sv - EX2 load/store response stage: waits on dcache, aligns/extends load data,
// holds the result for writeback and drops the in-flight response after a flush.
module ex2_mem_resp (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        flush,
  input  logic        ex1_mem_valid,
  input  logic        ex1_mem_op,
  input  logic [1:0]  ex1_mem_size,
  input  logic        ex1_mem_unsigned,
  input  logic        ex1_mem_atom,
  input  logic [1:0]  ex1_addr_low,
  input  logic [4:0]  ex1_rd,
  output logic        ex2_allowin,
  input  logic        dcache_resp_valid,
  input  logic [31:0] dcache_rdata,
  input  logic        wb_allowin,
  output logic        mem_wb_valid,
  output logic [4:0]  mem_wb_rd,
  output logic [31:0] mem_wb_data,
  output logic        mem_fwd_valid,
  output logic        mem_busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      state, state_nxt;
  logic        req_op, req_unsigned, req_atom;
  logic [1:0]  req_size, req_addr;
  logic [4:0]  req_rd;
  logic        accept, capture, hold_clear;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] result_data;
  logic [4:0]  result_rd;

  assign ex2_allowin   = ~flush & ((state == S_IDLE) | ((state == S_HOLD) & wb_allowin));
  assign accept        = ex1_mem_valid & ex2_allowin;
  assign capture       = (state == S_WAIT) & dcache_resp_valid & ~flush;
  assign hold_clear    = (state == S_HOLD) & (wb_allowin | flush);
  assign mem_fwd_valid = mem_wb_valid & (mem_wb_rd != 5'd0);
  assign mem_busy      = (state == S_WAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_WAIT;
      S_WAIT: begin
        if (flush)                  state_nxt = dcache_resp_valid ? S_IDLE : S_DRAIN;
        else if (dcache_resp_valid) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (flush)           state_nxt = S_IDLE;
        else if (wb_allowin) state_nxt = accept ? S_WAIT : S_IDLE;
      end
      // The single outstanding response retires the drain even if flush is still high.
      S_DRAIN: if (dcache_resp_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    byte_sel = dcache_rdata[7:0];
    case (req_addr)
      2'd0: byte_sel = dcache_rdata[7:0];
      2'd1: byte_sel = dcache_rdata[15:8];
      2'd2: byte_sel = dcache_rdata[23:16];
      2'd3: byte_sel = dcache_rdata[31:24];
      default: byte_sel = dcache_rdata[7:0];
    endcase
    half_sel    = req_addr[1] ? dcache_rdata[31:16] : dcache_rdata[15:0];
    result_data = dcache_rdata;
    result_rd   = req_rd;
    if (req_op) begin
      result_data = req_atom ? {31'b0, dcache_rdata[0]} : 32'b0;
      if (!req_atom) result_rd = 5'd0;
    end else if (!req_atom) begin
      case (req_size)
        2'd0:    result_data = {{24{~req_unsigned & byte_sel[7]}}, byte_sel};
        2'd1:    result_data = {{16{~req_unsigned & half_sel[15]}}, half_sel};
        default: result_data = dcache_rdata;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= S_IDLE;
      req_op       <= 1'b0;
      req_size     <= 2'd0;
      req_unsigned <= 1'b0;
      req_atom     <= 1'b0;
      req_addr     <= 2'd0;
      req_rd       <= 5'd0;
      mem_wb_valid <= 1'b0;
      mem_wb_rd    <= 5'd0;
      mem_wb_data  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_op       <= ex1_mem_op;
        req_size     <= ex1_mem_size;
        req_unsigned <= ex1_mem_unsigned;
        req_atom     <= ex1_mem_atom;
        req_addr     <= ex1_addr_low;
        req_rd       <= ex1_rd;
      end
      if (capture) begin
        mem_wb_valid <= 1'b1;
        mem_wb_rd    <= result_rd;
        mem_wb_data  <= result_data;
      end else if (hold_clear) begin
        mem_wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex2_mem_resp.sv
// tb/tb_ex2_mem_resp.sv - self-checking bench for ex2_mem_resp with a behavioural result model.
module tb_ex2_mem_resp;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        flush = 1'b0;
  logic        ex1_mem_valid = 1'b0;
  logic        ex1_mem_op = 1'b0;
  logic [1:0]  ex1_mem_size = 2'd0;
  logic        ex1_mem_unsigned = 1'b0;
  logic        ex1_mem_atom = 1'b0;
  logic [1:0]  ex1_addr_low = 2'd0;
  logic [4:0]  ex1_rd = 5'd0;
  logic        ex2_allowin;
  logic        dcache_resp_valid = 1'b0;
  logic [31:0] dcache_rdata = 32'd0;
  logic        wb_allowin = 1'b0;
  logic        mem_wb_valid;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        mem_fwd_valid;
  logic        mem_busy;

  int tests = 0;
  int fails = 0;

  ex2_mem_resp dut (
    .clk(clk), .aresetn(aresetn), .flush(flush),
    .ex1_mem_valid(ex1_mem_valid), .ex1_mem_op(ex1_mem_op), .ex1_mem_size(ex1_mem_size),
    .ex1_mem_unsigned(ex1_mem_unsigned), .ex1_mem_atom(ex1_mem_atom),
    .ex1_addr_low(ex1_addr_low), .ex1_rd(ex1_rd), .ex2_allowin(ex2_allowin),
    .dcache_resp_valid(dcache_resp_valid), .dcache_rdata(dcache_rdata),
    .wb_allowin(wb_allowin), .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd),
    .mem_wb_data(mem_wb_data), .mem_fwd_valid(mem_fwd_valid), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  // Reference result, from the byte/half/word rules using plain arithmetic.
  function automatic logic [31:0] ref_data(input logic op, input logic [1:0] size,
      input logic uns, input logic atom, input logic [1:0] addr, input logic [31:0] rdata);
    logic [31:0] v;
    if (op) return atom ? (rdata % 2) : 32'd0;
    if (atom || size >= 2) return rdata;
    if (size == 0) begin
      v = (rdata >> (8 * addr)) % 256;
      if (!uns && v >= 128) v = v - 256;
    end else begin
      v = (rdata >> (16 * (addr / 2))) % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [4:0] ref_rd(input logic op, input logic atom, input logic [4:0] rd);
    return (op && !atom) ? 5'd0 : rd;
  endfunction

  task automatic issue(input logic op, input logic [1:0] size, input logic uns,
                       input logic atom, input logic [1:0] addr, input logic [4:0] rd);
    @(posedge clk); #1;
    ex1_mem_valid = 1'b1; ex1_mem_op = op; ex1_mem_size = size;
    ex1_mem_unsigned = uns; ex1_mem_atom = atom; ex1_addr_low = addr; ex1_rd = rd;
    @(posedge clk); #1;
    ex1_mem_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    dcache_resp_valid = 1'b1; dcache_rdata = d;
    @(posedge clk); #1;
    dcache_resp_valid = 1'b0;
  endtask

  task automatic release_wb;
    wb_allowin = 1'b1;
    @(posedge clk); #1;
    wb_allowin = 1'b0;
  endtask

  task automatic test_reset;
    tests++; if (mem_wb_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", mem_wb_valid); end
    tests++; if (mem_wb_rd !== 5'd0) begin fails++; $display("FAIL reset_rd got %0d want 0", mem_wb_rd); end
    tests++; if (mem_wb_data !== 32'd0) begin fails++; $display("FAIL reset_data got %h want 0", mem_wb_data); end
    tests++; if (mem_fwd_valid !== 1'b0) begin fails++; $display("FAIL reset_fwd got %b want 0", mem_fwd_valid); end
    tests++; if (mem_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", mem_busy); end
    tests++; if (ex2_allowin !== 1'b1) begin fails++; $display("FAIL reset_allowin got %b want 1", ex2_allowin); end
  endtask

  task automatic test_loads;
    logic [1:0]  addr_t [4] = '{2'd3, 2'd3, 2'd2, 2'd0};
    logic [1:0]  size_t [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        uns_t  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] rdat_t [4] = '{32'h80FF_1234, 32'h80FF_1234, 32'h7FFE_8001, 32'h7FFE_8001};
    logic [31:0] want_t [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7FFE, 32'hFFFF_8001};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, size_t[i], uns_t[i], 1'b0, addr_t[i], 5'd7);
      tests++; if (mem_busy !== 1'b1) begin fails++; $display("FAIL load%0d_busy got %b want 1", i, mem_busy); end
      respond(rdat_t[i]);
      tests++; if (mem_wb_valid !== 1'b1) begin fails++; $display("FAIL load%0d_valid got %b want 1", i, mem_wb_valid); end
      tests++; if (mem_wb_data !== want_t[i]) begin fails++; $display("FAIL load%0d_data got %h want %h", i, mem_wb_data, want_t[i]); end
      tests++; if (mem_wb_rd !== 5'd7) begin fails++; $display("FAIL load%0d_rd got %0d want 7", i, mem_wb_rd); end
      release_wb;
      tests++; if (mem_wb_valid !== 1'b0) begin fails++; $display("FAIL load%0d_clear got %b want 0", i, mem_wb_valid); end
    end
  endtask

  task automatic test_sc_store;
    issue(1'b1, 2'd2, 1'b0, 1'b1, 2'd0, 5'd5);
    respond(32'hFFFF_FFFE);
    tests++; if (mem_wb_data !== 32'd0) begin fails++; $display("FAIL sc_data got %h want 0", mem_wb_data); end
    tests++; if (mem_wb_rd !== 5'd5) begin fails++; $display("FAIL sc_rd got %0d want 5", mem_wb_rd); end
    tests++; if (mem_fwd_valid !== 1'b1) begin fails++; $display("FAIL sc_fwd got %b want 1", mem_fwd_valid); end
    release_wb;
    issue(1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 5'd9);
    respond(32'h1234_5679);
    tests++; if (mem_wb_valid !== 1'b1) begin fails++; $display("FAIL st_valid got %b want 1", mem_wb_valid); end
    tests++; if (mem_wb_rd !== 5'd0) begin fails++; $display("FAIL st_rd got %0d want 0", mem_wb_rd); end
    tests++; if (mem_fwd_valid !== 1'b0) begin fails++; $display("FAIL st_fwd got %b want 0", mem_fwd_valid); end
    release_wb;
  endtask

  task automatic test_random;
    logic op, uns, atom;
    logic [1:0] size, addr;
    logic [4:0] rd;
    logic [31:0] rdata, exp_d;
    logic [4:0] exp_r;
    for (int i = 0; i < 40; i++) begin
      op = 1'($urandom); uns = 1'($urandom); size = 2'($urandom);
      addr = 2'($urandom); rd = 5'($urandom); rdata = $urandom;
      atom = (op || size == 2'd2) ? 1'($urandom) : 1'b0;
      exp_d = ref_data(op, size, uns, atom, addr, rdata);
      exp_r = ref_rd(op, atom, rd);
      issue(op, size, uns, atom, addr, rd);
      repeat ($urandom_range(0, 3)) begin
        tests++; if (mem_busy !== 1'b1 || mem_wb_valid !== 1'b0) begin fails++; $display("FAIL rand%0d_wait got busy=%b valid=%b want 1/0", i, mem_busy, mem_wb_valid); end
        @(posedge clk); #1;
      end
      respond(rdata);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      tests++; if (mem_wb_data !== exp_d) begin fails++; $display("FAIL rand%0d_data got %h want %h", i, mem_wb_data, exp_d); end
      tests++; if (mem_wb_rd !== exp_r) begin fails++; $display("FAIL rand%0d_rd got %0d want %0d", i, mem_wb_rd, exp_r); end
      tests++; if (mem_fwd_valid !== (exp_r != 5'd0)) begin fails++; $display("FAIL rand%0d_fwd got %b want %b", i, mem_fwd_valid, exp_r != 5'd0); end
      release_wb;
    end
  endtask

  task automatic test_back_to_back;
    issue(1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 5'd3);
    respond(32'hCAFE_F00D);
    for (int c = 0; c < 3; c++) begin
      tests++; if (mem_wb_data !== 32'hCAFE_F00D || mem_wb_rd !== 5'd3 || mem_wb_valid !== 1'b1) begin
        fails++; $display("FAIL hold%0d got %h/%0d/%b want cafef00d/3/1", c, mem_wb_data, mem_wb_rd, mem_wb_valid); end
      tests++; if (ex2_allowin !== 1'b0) begin fails++; $display("FAIL hold%0d_allowin got %b want 0", c, ex2_allowin); end
      @(posedge clk); #1;
    end
    wb_allowin = 1'b1; ex1_mem_valid = 1'b1; ex1_mem_op = 1'b0; ex1_mem_size = 2'd0;
    ex1_mem_unsigned = 1'b1; ex1_mem_atom = 1'b0; ex1_addr_low = 2'd1; ex1_rd = 5'd4;
    #1;
    tests++; if (ex2_allowin !== 1'b1) begin fails++; $display("FAIL b2b_allowin got %b want 1", ex2_allowin); end
    @(posedge clk); #1;
    wb_allowin = 1'b0; ex1_mem_valid = 1'b0;
    tests++; if (mem_busy !== 1'b1 || mem_wb_valid !== 1'b0) begin fails++; $display("FAIL b2b_wait got busy=%b valid=%b want 1/0", mem_busy, mem_wb_valid); end
    respond(32'h0000_A500);
    tests++; if (mem_wb_data !== 32'h0000_00A5 || mem_wb_rd !== 5'd4) begin fails++; $display("FAIL b2b_data got %h/%0d want a5/4", mem_wb_data, mem_wb_rd); end
    release_wb;
  endtask

  task automatic test_flush;
    issue(1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 5'd6);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; ex1_mem_valid = 1'b1; ex1_rd = 5'd8;
    #1;
    tests++; if (ex2_allowin !== 1'b0 || mem_busy !== 1'b0) begin fails++; $display("FAIL drain_a got allowin=%b busy=%b want 0/0", ex2_allowin, mem_busy); end
    @(posedge clk); #1;
    tests++; if (ex2_allowin !== 1'b0 || mem_wb_valid !== 1'b0) begin fails++; $display("FAIL drain_b got allowin=%b valid=%b want 0/0", ex2_allowin, mem_wb_valid); end
    ex1_mem_valid = 1'b0;
    respond(32'h1111_2222);
    tests++; if (mem_wb_valid !== 1'b0 || ex2_allowin !== 1'b1 || mem_busy !== 1'b0) begin
      fails++; $display("FAIL drain_end got valid=%b allowin=%b busy=%b want 0/1/0", mem_wb_valid, ex2_allowin, mem_busy); end
    issue(1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 5'd6);
    flush = 1'b1;
    respond(32'h3333_4444);
    flush = 1'b0;
    #1;
    tests++; if (mem_wb_valid !== 1'b0 || ex2_allowin !== 1'b1 || mem_busy !== 1'b0) begin
      fails++; $display("FAIL flush_same got valid=%b allowin=%b busy=%b want 0/1/0", mem_wb_valid, ex2_allowin, mem_busy); end
  endtask

  task automatic test_async_reset;
    issue(1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 5'd12);
    respond(32'hDEAD_BEEF);
    #2 aresetn = 1'b0;
    #1;
    tests++; if ({mem_wb_valid, mem_wb_rd, mem_wb_data, mem_fwd_valid, mem_busy} !== 40'd0) begin
      fails++; $display("FAIL areset got valid=%b rd=%0d data=%h fwd=%b busy=%b want all 0", mem_wb_valid, mem_wb_rd, mem_wb_data, mem_fwd_valid, mem_busy); end
    @(posedge clk); #1 aresetn = 1'b1;
    respond(32'h5555_AAAA);
    tests++; if (mem_wb_valid !== 1'b0 || mem_wb_data !== 32'd0 || ex2_allowin !== 1'b1 || mem_busy !== 1'b0) begin
      fails++; $display("FAIL spurious got valid=%b data=%h allowin=%b busy=%b want 0/0/1/0", mem_wb_valid, mem_wb_data, ex2_allowin, mem_busy); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    test_reset;
    test_loads;
    test_sc_store;
    test_random;
    test_back_to_back;
    test_flush;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
